// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbiter.
//   - Opcode encodings understood by alu.
//   - State encoding for the alu_arbiter control FSM.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;  // a + b, mod 2^DATA_W
    localparam logic [2:0] OP_SUB = 3'b001;  // a - b, mod 2^DATA_W
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;  // a << b, truncated
    localparam logic [2:0] OP_SHR = 3'b110;  // a >> b, logical
    localparam logic [2:0] OP_GT  = 3'b111;  // 1 if a > b else 0

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between client blocks and alu_arbiter.
//   req_valid/req_ready  per-requester request handshake
//   req_a/req_b/req_op   packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready  per-requester response handshake
//   rsp_result/rsp_zero  shared result and zero flag
//   busy                 arbiter has a transaction in flight
// master: client side, slave: arbiter side.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 4,
    parameter int OP_W    = 3
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_zero;
    logic                      busy;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, busy
    );
endinterface

// File: rtl/alu.sv
// Combinational 4-bit ALU.
//   rst     forces result to 0 while high
//   a, b    operands
//   op      opcode (see alu_pkg)
//   result  operation result, truncated to DATA_W
//   zero    high when result is 0
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
) (
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        result = '0;
        if (!rst) begin
            unique case (op)
                OP_ADD:  result = a + b;
                OP_SUB:  result = a - b;
                OP_AND:  result = a & b;
                OP_OR:   result = a | b;
                OP_XOR:  result = a ^ b;
                OP_SHL:  result = a << b;
                OP_SHR:  result = a >> b;
                OP_GT:   result = {{(DATA_W-1){1'b0}}, (a > b)};
                default: result = '0;
            endcase
        end
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between NUM_REQ requesters with round-robin arbitration and
// a single operation in flight: IDLE (arbitrate) -> EXEC (alu) -> RESP (hold).
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  alu_arbiter_if slave port (request/response channels, busy)
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 4,
    parameter int OP_W    = 3
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   last_grant;
    logic [DATA_W-1:0]  opnd_a;
    logic [DATA_W-1:0]  opnd_b;
    logic [OP_W-1:0]    opnd_op;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_result_q;
    logic               rsp_zero_q;
    logic               busy_q;

    logic [IDX_W-1:0]   pick;
    logic               pick_found;
    logic [NUM_REQ-1:0] req_ready;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_zero;

    // Returns {found, index} of the first valid requester after `last`, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   last);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        {pick_found, pick} = rr_pick(bus.req_valid, last_grant);
        req_ready = '0;
        // Gated by rst so no handshake appears while the arbiter is held in reset.
        if (state == IDLE && !rst && pick_found) begin
            req_ready[pick] = 1'b1;
        end
    end

    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .rst    (rst),
        .a      (opnd_a),
        .b      (opnd_b),
        .op     (opnd_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            last_grant   <= IDX_W'(NUM_REQ - 1);  // requester 0 wins first
            opnd_a       <= '0;
            opnd_b       <= '0;
            opnd_op      <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A found requester is already being shown req_ready, so this is the handshake.
                    if (pick_found) begin
                        opnd_a     <= bus.req_a[int'(pick)*DATA_W +: DATA_W];
                        opnd_b     <= bus.req_b[int'(pick)*DATA_W +: DATA_W];
                        opnd_op    <= bus.req_op[int'(pick)*OP_W +: OP_W];
                        grant      <= pick;
                        last_grant <= pick;
                        busy_q     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_zero_q   <= alu_zero;
                    rsp_valid_q  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[grant]) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (NUM_REQ=2): directed table, hand-written
// reset/drop sequences, then random transactions against a behavioural model.
module tb_alu_arbiter;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_arbiter_if #(.NUM_REQ(N), .DATA_W(4), .OP_W(3)) bus ();

    alu_arbiter #(.NUM_REQ(N), .DATA_W(4), .OP_W(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int model_last = N - 1;

    typedef struct {
        logic [1:0] mask;
        logic [3:0] a0, b0;
        logic [2:0] op0;
        logic [3:0] a1, b1;
        logic [2:0] op1;
        int         delay;
        bit         hold;
        int         exp_g;
        logic [3:0] exp_res;
        logic       exp_z;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input int g);
        return 2'(1 << g);
    endfunction

    // Behavioural ALU: plain integer arithmetic on the operand values.
    function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        case (op)
            3'd0:    r = (ai + bi) % 16;
            3'd1:    r = (ai - bi + 16) % 16;
            3'd2:    r = ai & bi;
            3'd3:    r = ai | bi;
            3'd4:    r = ai ^ bi;
            3'd5:    r = (ai * (2 ** bi)) % 16;
            3'd6:    r = ai / (2 ** bi);
            default: r = (ai > bi) ? 1 : 0;
        endcase
        return 4'(r);
    endfunction

    // Round-robin: the valid requester at the smallest cyclic distance after the last grant.
    function automatic int ref_pick(input logic [1:0] mask, input int last);
        int best, bestd, d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - last - 1 + N) % N;
            if (mask[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    // Entered and left at 1 time unit after a rising edge with the DUT in IDLE.
    task automatic do_txn(input string tag, input vec_t v);
        logic [1:0] g1h;
        g1h = onehot(v.exp_g);
        bus.req_a     = {v.a1, v.a0};
        bus.req_b     = {v.b1, v.b0};
        bus.req_op    = {v.op1, v.op0};
        bus.req_valid = v.mask;
        bus.rsp_ready = v.hold ? 2'b11 : 2'b00;
        #1;
        check({tag, " grant"}, 32'(bus.req_ready), 32'(g1h));
        check({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        model_last = v.exp_g;
        // Operands changed after acceptance must not affect the result.
        bus.req_valid = 2'b00;
        bus.req_a     = 8'($urandom);
        bus.req_b     = 8'($urandom);
        bus.req_op    = 6'($urandom);
        check({tag, " exec_busy"}, 32'(bus.busy), 32'd1);
        check({tag, " exec_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(g1h));
        check({tag, " result"}, 32'(bus.rsp_result), 32'(v.exp_res));
        check({tag, " zero"}, 32'(bus.rsp_zero), 32'(v.exp_z));
        for (int d = 0; d < v.delay; d++) begin
            bus.req_valid = 2'b11;
            bus.rsp_ready = ~g1h;
            #1;
            check({tag, " resp_req_ready"}, 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
            check({tag, " held_valid"}, 32'(bus.rsp_valid), 32'(g1h));
            check({tag, " held_result"}, 32'(bus.rsp_result), 32'(v.exp_res));
            check({tag, " held_zero"}, 32'(bus.rsp_zero), 32'(v.exp_z));
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = v.hold ? 2'b11 : g1h;
        @(posedge clk); #1;
        check({tag, " rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " done_busy"}, 32'(bus.busy), 32'd0);
        bus.rsp_ready = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //            mask   a0    b0    op0     a1     b1    op1    dly hold g  res    z
        tbl[0] = '{2'b01, 4'd9, 4'd8, 3'b000, 4'd0, 4'd0, 3'b000, 1, 0, 0, 4'd1,  1'b0};
        tbl[1] = '{2'b10, 4'd0, 4'd0, 3'b000, 4'd5, 4'd5, 3'b001, 0, 1, 1, 4'd0,  1'b1};
        tbl[2] = '{2'b11, 4'd2, 4'd3, 3'b000, 4'd9, 4'd4, 3'b110, 0, 0, 0, 4'd5,  1'b0};
        tbl[3] = '{2'b11, 4'd2, 4'd3, 3'b000, 4'd9, 4'd4, 3'b110, 0, 0, 1, 4'd0,  1'b1};
        tbl[4] = '{2'b11, 4'd6, 4'd3, 3'b010, 4'd9, 4'd4, 3'b110, 0, 0, 0, 4'd2,  1'b0};
        tbl[5] = '{2'b01, 4'd3, 4'd5, 3'b101, 4'd0, 4'd0, 3'b000, 5, 0, 0, 4'd0,  1'b1};
        tbl[6] = '{2'b01, 4'd12,4'd10,3'b100, 4'd0, 4'd0, 3'b000, 0, 0, 0, 4'd6,  1'b0};
        tbl[7] = '{2'b10, 4'd0, 4'd0, 3'b000, 4'd13,4'd6, 3'b011, 2, 0, 1, 4'd15, 1'b0};
        tbl[8] = '{2'b10, 4'd0, 4'd0, 3'b000, 4'd9, 4'd3, 3'b111, 0, 0, 1, 4'd1,  1'b0};
        tbl[9] = '{2'b01, 4'd2, 4'd5, 3'b001, 4'd0, 4'd0, 3'b000, 0, 1, 0, 4'd13, 1'b0};

        // Reset, with both requests raised to show nothing is granted meanwhile.
        bus.req_valid = 2'b11;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 2'b00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", 32'(bus.req_ready), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset result", 32'(bus.rsp_result), 32'd0);
        check("reset zero", 32'(bus.rsp_zero), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        bus.req_valid = 2'b00;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_txn($sformatf("tbl%0d", i), tbl[i]);
        end

        // Request withdrawn before the edge: no grant, no state change.
        bus.req_valid = 2'b01;
        #1;
        check("drop req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        check("drop busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check("drop rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Reset while in EXEC: transaction discarded, pointer back to requester 0.
        bus.req_a     = {4'd7, 4'd0};
        bus.req_b     = {4'd2, 4'd0};
        bus.req_op    = {3'b111, 3'b000};
        bus.req_valid = 2'b10;
        #1;
        check("rstx grant", 32'(bus.req_ready), 32'd2);
        @(posedge clk); #1;
        check("rstx exec_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        @(posedge clk); #1;
        check("rstx rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstx busy", 32'(bus.busy), 32'd0);
        check("rstx result", 32'(bus.rsp_result), 32'd0);
        check("rstx zero", 32'(bus.rsp_zero), 32'd0);
        check("rstx req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        model_last = N - 1;
        @(posedge clk); #1;
        check("rstx no_rsp", 32'(bus.rsp_valid), 32'd0);
        v = '{2'b11, 4'd4, 4'd4, 3'b001, 4'd1, 4'd1, 3'b000, 0, 0, 0, 4'd0, 1'b1};
        v.exp_g = ref_pick(v.mask, model_last);
        do_txn("rstx next", v);
        check("rstx next_was_req0", 32'(model_last), 32'd0);

        // Random transactions checked against the behavioural model.
        for (int i = 0; i < 40; i++) begin
            v.mask  = 2'($urandom_range(1, 3));
            v.a0    = 4'($urandom);
            v.b0    = 4'($urandom);
            v.op0   = 3'($urandom);
            v.a1    = 4'($urandom);
            v.b1    = 4'($urandom);
            v.op1   = 3'($urandom);
            v.delay = $urandom_range(0, 3);
            v.hold  = (v.delay == 0) && ($urandom_range(0, 1) == 1);
            v.exp_g = ref_pick(v.mask, model_last);
            v.exp_res = (v.exp_g == 0) ? ref_alu(v.a0, v.b0, v.op0) : ref_alu(v.a1, v.b1, v.op1);
            v.exp_z   = (v.exp_res == 4'd0);
            do_txn($sformatf("rnd%0d", i), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
